// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of an external simple dual-port
// RAM (one write port A, one registered read port B, common clock).
// Words enter on s_*, go into the RAM and are read back through a
// two-entry output buffer that drives m_*. The RAM read latency is hidden
// by the buffer, so one word per cycle flows in and out.
//
// Optional feature: define RAM_FIFO_CNT_EN to add the registered fill_cnt
// output (RAM words + read in flight + buffered words).
module ram_fifo_ctrl #(
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  ram_wea,
  output logic                  ram_ena,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_wr_dataa,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_rd_datab
`ifdef RAM_FIFO_CNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] fill_cnt
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);

  // Pointers carry one extra bit so that full (count == DEPTH) and empty
  // (count == 0) are distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt;

  // Output buffer: buf0 is always the oldest entry and feeds m_data.
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q, inflight_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  pop;
  logic [2:0]            slots_used;
  logic [2:0]            slots_limit;

  assign ram_cnt = wr_ptr_q - rd_ptr_q;

  // Handshakes; everything is held off while reset is asserted.
  assign s_ready = !rst && (ram_cnt < DEPTH_P);
  assign wr_fire = s_valid && s_ready;
  assign m_valid = !rst && (buf_cnt_q != 2'd0);
  assign m_data  = rst ? '0 : buf0_q;
  assign pop     = m_valid && m_ready;

  // A read may be issued only if its word is guaranteed a buffer slot on
  // arrival: entries + in-flight - pop < 2, rewritten without subtraction.
  assign slots_used  = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
  assign slots_limit = 3'd2 + {2'b00, pop};
  assign rd_fire     = !rst && (ram_cnt != '0) && (slots_used < slots_limit);

  // RAM port drive; addresses and data are forced to zero when idle.
  assign ram_wea      = wr_fire;
  assign ram_ena      = wr_fire;
  assign ram_addra    = wr_fire ? wr_ptr_q[ADDR_WIDTH-1:0] : '0;
  assign ram_wr_dataa = wr_fire ? s_data : '0;
  assign ram_enb      = rd_fire;
  assign ram_addrb    = rd_fire ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;

  // Pointer and in-flight next state; pointers wrap modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_fire};
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
    inflight_d = rd_fire;
  end

  // Output buffer next state: shift out on pop, then append returning data
  // behind whatever is left, so buf0 never changes while stalled.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      if (buf_cnt_d == 2'd0) begin
        buf0_d = ram_rd_datab;
      end else begin
        buf1_d = ram_rd_datab;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  // State registers; reset drops stored words and any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef RAM_FIFO_CNT_EN
  logic [ADDR_WIDTH+1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH:0]   ram_cnt_d;

  // Total words held anywhere in the block, computed from next-state values.
  always_comb begin
    ram_cnt_d  = wr_ptr_d - rd_ptr_d;
    fill_cnt_d = {1'b0, ram_cnt_d}
               + {{(ADDR_WIDTH+1){1'b0}}, inflight_d}
               + {{ADDR_WIDTH{1'b0}}, buf_cnt_d};
  end

  // Registered fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign fill_cnt = fill_cnt_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: behavioural RAM model plus a scoreboard
// queue filled on accepted input words and drained on output pops.
// Define RAM_FIFO_CNT_EN to also check fill_cnt.
module tb_ram_fifo_ctrl;
  localparam int DEPTH = 2048;
  localparam int DW    = 12;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          ram_wea;
  logic          ram_ena;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_wr_dataa;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_rd_datab;
`ifdef RAM_FIFO_CNT_EN
  logic [AW+1:0] fill_cnt;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .ram_wea(ram_wea),
    .ram_ena(ram_ena),
    .ram_addra(ram_addra),
    .ram_wr_dataa(ram_wr_dataa),
    .ram_enb(ram_enb),
    .ram_addrb(ram_addrb),
    .ram_rd_datab(ram_rd_datab)
`ifdef RAM_FIFO_CNT_EN
    ,
    .fill_cnt(fill_cnt)
`endif
  );

  // Simple dual-port RAM with one-cycle registered read.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_wr_dataa;
    if (ram_enb) ram_rd_datab <= mem[ram_addrb];
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q [$];
  bit            verbose  = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [AW-1:0] exp_wa = '0;
  logic [AW-1:0] exp_rb = '0;
  int            wrap_a = 0;
  int            wrap_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, describes the transfer at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev <= 1'b0;
      exp_wa     <= '0;
      exp_rb     <= '0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held_data);
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          if (verbose) $display("out word 0x%03h (expected 0x%03h)", m_data, exp_q[0]);
          check("sb_data", m_data, exp_q.pop_front());
        end
      end
      if (ram_wea) begin
        check("addra_seq", ram_addra, exp_wa);
        if (ram_addra == AW'(DEPTH - 1)) wrap_a++;
        exp_wa <= ram_addra + 1'b1;
      end
      if (ram_enb) begin
        check("addrb_seq", ram_addrb, exp_rb);
        if (ram_addrb == AW'(DEPTH - 1)) wrap_b++;
        exp_rb <= ram_addrb + 1'b1;
      end
      stall_prev <= m_valid && !m_ready;
      held_data  <= m_data;
    end
  end

  task automatic drain(input string tag);
    int c;
    c = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && c < 6000) begin
      tick();
      c++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_mvalid"}, m_valid, 0);
  endtask

  initial begin
    int acc, gaps, low, w, cyc, wa0, wb0;
    bit take, rose;

    // Reset state, with live-looking inputs to make sure they are ignored.
    rst = 1'b1; s_valid = 1'b1; s_data = 12'h5A5; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_wea", ram_wea, 0);
    check("rst_ena", ram_ena, 0);
    check("rst_enb", ram_enb, 0);
    check("rst_addra", ram_addra, 0);
    check("rst_wdata", ram_wr_dataa, 0);
`ifdef RAM_FIFO_CNT_EN
    check("rst_fill", fill_cnt, 0);
`endif
    s_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_s_ready", s_ready, 1);

    // Single word: visible exactly two edges after acceptance.
    verbose = 1'b1;
    s_valid = 1'b1; s_data = 12'hABC; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("lat_n0", m_valid, 0);
    tick();
    check("lat_n1", m_valid, 0);
    tick();
    check("lat_n2_valid", m_valid, 1);
    check("lat_n2_data", m_data, 12'hABC);
    tick();
    check("lat_n3_valid", m_valid, 0);
    verbose = 1'b0;

    // Streaming at full rate.
    gaps = 0; low = 0;
    for (int i = 0; i < 4096; i++) begin
      s_valid = 1'b1; s_data = 12'(i);
      if (!s_ready) low++;
      tick();
      if (i >= 2 && !m_valid) gaps++;
    end
    check("stream_sready_low", low, 0);
    check("stream_gaps", gaps, 0);
    drain("stream_drain");

    // Fill to full with the output stalled.
    m_ready = 1'b0; acc = 0; s_valid = 1'b1; s_data = 12'(acc);
    for (int c = 0; c < 3000 && s_ready; c++) begin
      tick();
      acc++;
      s_data = 12'(acc);
    end
    s_valid = 1'b0;
    check("full_count", acc, DEPTH + 2);
`ifdef RAM_FIFO_CNT_EN
    check("full_fill", fill_cnt, DEPTH + 2);
`endif
    tick();
    check("full_sready", s_ready, 0);
    check("full_mvalid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rose = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (s_ready) rose = 1'b1;
    end
    check("repop_sready", rose, 1);
    drain("full_drain");

    // Random backpressure and random input gaps.
    w = 0; cyc = 0;
    while (w < 10000 && cyc < 60000) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 12'(w * 7 + 3);
      take    = s_valid && s_ready;
      tick();
      if (take) w++;
      cyc++;
    end
    check("bp_sent", w, 10000);
    drain("bp_drain");

    // Reset with 100 words stored.
    verbose = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 12'(i + 'h200);
      tick();
    end
    s_valid = 1'b0;
    tick();
`ifdef RAM_FIFO_CNT_EN
    check("pre_rst_fill", fill_cnt, 100);
`endif
    rst = 1'b1;
    tick();
    check("mid_rst_sready", s_ready, 0);
    rst = 1'b0;
    check("post_rst_mvalid", m_valid, 0);
`ifdef RAM_FIFO_CNT_EN
    check("post_rst_fill", fill_cnt, 0);
`endif
    s_valid = 1'b1; s_data = 12'h123; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    check("post_rst_first_valid", m_valid, 1);
    check("post_rst_first_data", m_data, 12'h123);
    drain("rst_drain");
    verbose = 1'b0;

    // Address wrap with occupancy held near DEPTH.
    wa0 = wrap_a; wb0 = wrap_b;
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH - 8; i++) begin
      s_valid = 1'b1; s_data = 12'(i * 3);
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      s_valid = 1'b1; s_data = 12'(i * 5 + 1);
      tick();
    end
    drain("wrap_drain");
    check("wrap_a", (wrap_a - wa0) >= 3, 1);
    check("wrap_b", (wrap_b - wb0) >= 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: RAM words managed; power of two.
REQ-002 SHALL have parameter DATA_WIDTH, default 12: pixel/word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 11: RAM address width; log2(DEPTH).
REQ-004 SHALL have port clk, input, 1: single clock; also drives RAM clka and clkb.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port s_valid, input, 1: upstream word valid.
REQ-007 SHALL have port s_data, input, DATA_WIDTH: upstream word.
REQ-008 SHALL have port s_ready, output, 1: block accepts word.
REQ-009 SHALL have port m_valid, output, 1: downstream word valid.
REQ-010 SHALL have port m_data, output, DATA_WIDTH: downstream word.
REQ-011 SHALL have port m_ready, input, 1: downstream accepts word.
REQ-012 SHALL have port ram_wea, output, 1: RAM write enable, to wea.
REQ-013 SHALL have port ram_ena, output, 1: RAM port A enable, to ena.
REQ-014 SHALL have port ram_addra, output, ADDR_WIDTH: write address, to addra.
REQ-015 SHALL have port ram_wr_dataa, output, DATA_WIDTH: write data, to wr_dataa.
REQ-016 SHALL have port ram_enb, output, 1: RAM port B read enable, to enb.
REQ-017 SHALL have port ram_addrb, output, ADDR_WIDTH: read address, to addrb.
REQ-018 SHALL have port ram_rd_datab, input, DATA_WIDTH: RAM read data, from rd_datab, valid 1 cycle after ram_enb.

Function
REQ-019 SHALL hold wr_ptr and rd_ptr, ADDR_WIDTH+1 bits each; RAM count = wr_ptr - rd_ptr (registered values).
REQ-020 SHALL drive s_ready = 1 when RAM count < DEPTH and not in reset; full: s_ready = 0.
REQ-021 SHALL, on s_valid && s_ready, combinationally assert ram_wea = ram_ena = 1, ram_addra = wr_ptr[ADDR_WIDTH-1:0], ram_wr_dataa = s_data, and increment wr_ptr at the clock edge.
REQ-022 SHALL keep a 2-entry output buffer; one read in flight at most per cycle; issue read (ram_enb = 1, ram_addrb = rd_ptr low bits, rd_ptr++) when RAM count > 0 and buffer entries + in-flight reads - (pop this cycle) < 2.
REQ-023 SHALL capture ram_rd_datab into the buffer the cycle after a read issue; zero-cycle bypass from RAM to m_data SHALL NOT exist.
REQ-024 SHALL drive m_valid = 1 when buffer non-empty; m_data = oldest entry; pop on m_valid && m_ready.
REQ-025 SHALL sustain 1 word/cycle in and out with m_ready held high after initial fill.
REQ-026 First-word latency: s_data accepted at edge N SHALL appear on m_data with m_valid at edge N+2 (write N, read N+1, capture N+2).
REQ-027 Simultaneous write and read-issue in one cycle SHALL be legal; a location is read only after its write edge, so no same-address collision occurs.
REQ-028 Pointers SHALL wrap modulo 2*DEPTH; address bits wrap modulo DEPTH.
REQ-029 Word order out SHALL equal word order in; no loss, no duplication.
REQ-030 m_data SHALL be held stable while m_valid && !m_ready.

Reset
REQ-031 On rst: wr_ptr = rd_ptr = 0, buffer empty, in-flight cleared; m_valid = 0, m_data = 0, s_ready = 0 during rst, ram_wea = ram_ena = ram_enb = 0, addresses and write data 0.
REQ-032 Reset mid-operation SHALL discard all stored and in-flight words; a RAM read completing the cycle after rst SHALL be ignored.

Configuration
REQ-033 Macro RAM_FIFO_CNT_EN defined: SHALL add output port fill_cnt, width ADDR_WIDTH+2, registered, = RAM count + in-flight + buffer entries, reset 0.
REQ-034 Macro RAM_FIFO_CNT_EN undefined: port fill_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Single word: after reset push 0xABC, m_ready = 1 -> m_valid = 1, m_data = 0xABC exactly 2 cycles after accept, then m_valid = 0.
REQ-036 Streaming: push 0..4095 continuously, m_ready = 1 -> output 0..4095 in order, one per cycle after 2-cycle latency, s_ready never low.
REQ-037 Full: m_ready = 0, push until s_ready = 0 -> exactly DEPTH + 2 = 2050 words accepted; fill_cnt = 2050 (with macro); single pop re-raises s_ready within 2 cycles.
REQ-038 Backpressure: toggle m_ready randomly at 50% over 10000 words -> in-order output, m_data stable while stalled, no loss.
REQ-039 Reset mid-stream: rst 1 cycle with 100 words stored -> next cycle m_valid = 0, fill_cnt = 0; new word 0x123 emerges first.
REQ-040 Wrap: push/pop 3*DEPTH words with occupancy near DEPTH -> ram_addra/ram_addrb wrap 2047 -> 0, data intact.
